// File: rtl/uart_mmio_fifo_pkg.sv
// Shared constants for the memory-mapped UART front-end: base address,
// register offsets, STATUS/CTRL bit positions and the CTRL layout.
package uart_mmio_fifo_pkg;

    localparam logic [31:0] UART_BASE_ADDR = 32'h0002_1000;

    typedef enum logic [1:0] {
        UART_DATA   = 2'd0,
        UART_STATUS = 2'd1,
        UART_CTRL   = 2'd2,
        UART_IRQ    = 2'd3
    } uart_reg_e;

    // STATUS bit positions
    localparam int unsigned ST_RX_NONEMPTY  = 0;
    localparam int unsigned ST_RX_FULL      = 1;
    localparam int unsigned ST_TX_EMPTY     = 2;
    localparam int unsigned ST_TX_FULL      = 3;
    localparam int unsigned ST_RX_OVERRUN   = 4;
    localparam int unsigned ST_TX_DROP      = 5;
    localparam int unsigned ST_RX_COUNT_LSB = 8;
    localparam int unsigned ST_TX_COUNT_LSB = 16;

    // CTRL bit positions
    localparam int unsigned CTRL_RX_IE       = 0;
    localparam int unsigned CTRL_TX_EMPTY_IE = 1;
    localparam int unsigned CTRL_ERR_IE      = 2;
    localparam int unsigned CTRL_THRESH_LSB  = 8;

    typedef struct packed {
        logic [7:0] rx_thresh;
        logic       err_ie;
        logic       tx_empty_ie;
        logic       rx_ie;
    } uart_ctrl_t;

    // A programmed threshold of zero behaves as one.
    function automatic logic [7:0] eff_thresh(input logic [7:0] t);
        return (t == 8'd0) ? 8'd1 : t;
    endfunction

endpackage

// File: rtl/cpu6_sync_fifo.sv
// Single-clock FIFO with registered count; head is the oldest entry
// (zero when empty). A push into a full FIFO is accepted only when a pop
// happens in the same cycle.
module cpu6_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned CW = $clog2(DEPTH + 1),
    localparam int unsigned PW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = empty ? '0 : mem[rd_ptr];

    // Storage write; contents are discarded on reset via the pointers.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping, wrapping modulo DEPTH.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_mmio_fifo.sv
// Memory-mapped UART front-end: TX/RX FIFOs, STATUS with sticky error
// bits, CTRL with interrupt enables and RX threshold, registered level irq.
module uart_mmio_fifo
    import uart_mmio_fifo_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned TX_DEPTH = 16,
    parameter int unsigned RX_DEPTH = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            sel,
    input  logic [1:0]      addr,
    input  logic            wr_en,
    input  logic            rd_en,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] rdata,
    output logic            irq,
    output logic [7:0]      tx_data,
    output logic            tx_data_valid,
    input  logic            tx_data_ack,
    input  logic [7:0]      rx_data,
    input  logic            rx_data_fresh
);

    localparam int unsigned TXCW = $clog2(TX_DEPTH + 1);
    localparam int unsigned RXCW = $clog2(RX_DEPTH + 1);

    uart_reg_e        reg_sel;
    uart_ctrl_t       ctrl;
    logic             rx_overrun;
    logic             tx_drop;

    logic             tx_push, tx_pop, tx_full, tx_empty;
    logic [TXCW-1:0]  tx_count;
    logic             rx_push, rx_pop, rx_full, rx_empty;
    logic [RXCW-1:0]  rx_count;
    logic [7:0]       rx_head;

    logic [7:0]       tx_count8, rx_count8;
    logic             wr_data, wr_status, wr_ctrl;
    logic             tx_drop_set, rx_overrun_set;
    logic [2:0]       pend;
    logic [31:0]      status_word;

    assign reg_sel   = uart_reg_e'(addr);
    assign wr_data   = sel & wr_en & (reg_sel == UART_DATA);
    assign wr_status = sel & wr_en & (reg_sel == UART_STATUS);
    assign wr_ctrl   = sel & wr_en & (reg_sel == UART_CTRL);

    assign tx_push       = wr_data;
    assign tx_pop        = tx_data_valid & tx_data_ack;
    assign tx_data_valid = ~tx_empty;
    assign rx_push       = rx_data_fresh;
    assign rx_pop        = sel & rd_en & (reg_sel == UART_DATA) & ~rx_empty;

    assign tx_drop_set    = tx_push & tx_full & ~tx_pop;
    assign rx_overrun_set = rx_push & rx_full & ~rx_pop;

    cpu6_sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (tx_push),
        .pop   (tx_pop),
        .din   (wdata[7:0]),
        .head  (tx_data),
        .count (tx_count),
        .full  (tx_full),
        .empty (tx_empty)
    );

    cpu6_sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (rx_push),
        .pop   (rx_pop),
        .din   (rx_data),
        .head  (rx_head),
        .count (rx_count),
        .full  (rx_full),
        .empty (rx_empty)
    );

    // Zero-extend the FIFO counts into their 8-bit STATUS fields.
    always_comb begin
        tx_count8 = '0;
        rx_count8 = '0;
        tx_count8[TXCW-1:0] = tx_count;
        rx_count8[RXCW-1:0] = rx_count;
    end

    // Interrupt pending terms from the current state.
    always_comb begin
        pend    = '0;
        pend[0] = (rx_count8 >= eff_thresh(ctrl.rx_thresh));
        pend[1] = tx_empty;
        pend[2] = rx_overrun | tx_drop;
    end

    // CTRL register and sticky error bits; a set beats a same-cycle W1C.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl       <= '0;
            rx_overrun <= 1'b0;
            tx_drop    <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                ctrl.rx_ie       <= wdata[CTRL_RX_IE];
                ctrl.tx_empty_ie <= wdata[CTRL_TX_EMPTY_IE];
                ctrl.err_ie      <= wdata[CTRL_ERR_IE];
                ctrl.rx_thresh   <= wdata[CTRL_THRESH_LSB +: 8];
            end
            rx_overrun <= rx_overrun_set |
                          (rx_overrun & ~(wr_status & wdata[ST_RX_OVERRUN]));
            tx_drop    <= tx_drop_set |
                          (tx_drop & ~(wr_status & wdata[ST_TX_DROP]));
        end
    end

    // Registered level interrupt, one cycle behind the state it reflects.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq <= 1'b0;
        end else begin
            irq <= |(pend & {ctrl.err_ie, ctrl.tx_empty_ie, ctrl.rx_ie});
        end
    end

    // STATUS word assembly.
    always_comb begin
        status_word = '0;
        status_word[ST_RX_NONEMPTY] = ~rx_empty;
        status_word[ST_RX_FULL]     = rx_full;
        status_word[ST_TX_EMPTY]    = tx_empty;
        status_word[ST_TX_FULL]     = tx_full;
        status_word[ST_RX_OVERRUN]  = rx_overrun;
        status_word[ST_TX_DROP]     = tx_drop;
        status_word[ST_RX_COUNT_LSB +: 8] = rx_count8;
        status_word[ST_TX_COUNT_LSB +: 8] = tx_count8;
    end

    // Combinational read mux; zero when not selected.
    always_comb begin
        rdata = '0;
        if (sel) begin
            case (reg_sel)
                UART_DATA:   rdata[7:0]  = rx_head;
                UART_STATUS: rdata[31:0] = status_word;
                UART_CTRL: begin
                    rdata[CTRL_RX_IE]            = ctrl.rx_ie;
                    rdata[CTRL_TX_EMPTY_IE]      = ctrl.tx_empty_ie;
                    rdata[CTRL_ERR_IE]           = ctrl.err_ie;
                    rdata[CTRL_THRESH_LSB +: 8]  = ctrl.rx_thresh;
                end
                UART_IRQ:    rdata[2:0]  = pend;
                default:     rdata       = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_mmio_fifo.sv
// Directed bench for uart_mmio_fifo: a vector table for register and TX
// basics, then hand-written sequences for overflow, threshold and reset.
module tb_uart_mmio_fifo;

    logic        clk = 1'b0;
    logic        reset;
    logic        sel;
    logic [1:0]  addr;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;
    logic [7:0]  tx_data;
    logic        tx_data_valid;
    logic        tx_data_ack;
    logic [7:0]  rx_data;
    logic        rx_data_fresh;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_mmio_fifo #(.XLEN(32), .TX_DEPTH(16), .RX_DEPTH(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .sel           (sel),
        .addr          (addr),
        .wr_en         (wr_en),
        .rd_en         (rd_en),
        .wdata         (wdata),
        .rdata         (rdata),
        .irq           (irq),
        .tx_data       (tx_data),
        .tx_data_valid (tx_data_valid),
        .tx_data_ack   (tx_data_ack),
        .rx_data       (rx_data),
        .rx_data_fresh (rx_data_fresh)
    );

    typedef struct {
        logic        s;
        logic [1:0]  a;
        logic        w;
        logic        r;
        logic [31:0] d;
        logic        ack;
        logic        fr;
        logic [7:0]  rx;
        logic [31:0] e_rdata;
        logic        e_irq;
        logic        e_txv;
        logic [7:0]  e_txd;
    } vec_t;

    vec_t vecs [18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One bus cycle: drive just after the edge, return at the following negedge.
    task automatic op(input logic s, input logic [1:0] a, input logic w, input logic r,
                      input logic [31:0] d, input logic ack, input logic fr, input logic [7:0] rx);
        @(posedge clk);
        #1;
        reset = 1'b0; sel = s; addr = a; wr_en = w; rd_en = r; wdata = d;
        tx_data_ack = ack; rx_data_fresh = fr; rx_data = rx;
        @(negedge clk);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        op(1'b1, a, 1'b1, 1'b0, d, 1'b0, 1'b0, 8'h00);
    endtask
    task automatic rreg(input logic [1:0] a);
        op(1'b1, a, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 8'h00);
    endtask
    task automatic rpop();
        op(1'b1, 2'd0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 8'h00);
    endtask
    task automatic idle();
        op(1'b0, 2'd0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 8'h00);
    endtask
    task automatic fresh(input logic [7:0] b);
        op(1'b0, 2'd0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, b);
    endtask
    task automatic ack();
        op(1'b0, 2'd0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 8'h00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //          s  a  w  r  wdata      ack fr rx      rdata       irq txv txd
        vecs[0]  = '{1, 1, 0, 0, 32'h0,     0, 0, 8'h0, 32'h0000_0004, 0, 0, 8'h00};
        vecs[1]  = '{1, 0, 1, 0, 32'h41,    0, 0, 8'h0, 32'h0000_0000, 0, 0, 8'h00};
        vecs[2]  = '{1, 0, 1, 0, 32'h42,    0, 0, 8'h0, 32'h0000_0000, 0, 1, 8'h41};
        vecs[3]  = '{1, 0, 1, 0, 32'h43,    0, 0, 8'h0, 32'h0000_0000, 0, 1, 8'h41};
        vecs[4]  = '{1, 1, 0, 0, 32'h0,     1, 0, 8'h0, 32'h0003_0000, 0, 1, 8'h41};
        vecs[5]  = '{1, 1, 0, 0, 32'h0,     1, 0, 8'h0, 32'h0002_0000, 0, 1, 8'h42};
        vecs[6]  = '{1, 1, 0, 0, 32'h0,     1, 0, 8'h0, 32'h0001_0000, 0, 1, 8'h43};
        vecs[7]  = '{1, 1, 0, 0, 32'h0,     0, 0, 8'h0, 32'h0000_0004, 0, 0, 8'h00};
        vecs[8]  = '{1, 2, 1, 0, 32'h302,   0, 0, 8'h0, 32'h0000_0000, 0, 0, 8'h00};
        vecs[9]  = '{1, 2, 0, 0, 32'h0,     0, 0, 8'h0, 32'h0000_0302, 0, 0, 8'h00};
        vecs[10] = '{1, 3, 0, 0, 32'h0,     0, 0, 8'h0, 32'h0000_0002, 1, 0, 8'h00};
        vecs[11] = '{1, 0, 1, 0, 32'h55,    0, 0, 8'h0, 32'h0000_0000, 1, 0, 8'h00};
        vecs[12] = '{1, 3, 0, 0, 32'h0,     0, 0, 8'h0, 32'h0000_0000, 1, 1, 8'h55};
        vecs[13] = '{0, 0, 0, 0, 32'h0,     1, 0, 8'h0, 32'h0000_0000, 0, 1, 8'h55};
        vecs[14] = '{0, 0, 0, 0, 32'h0,     0, 0, 8'h0, 32'h0000_0000, 0, 0, 8'h00};
        vecs[15] = '{1, 2, 1, 0, 32'h0,     0, 0, 8'h0, 32'h0000_0302, 1, 0, 8'h00};
        vecs[16] = '{0, 0, 0, 0, 32'h0,     0, 0, 8'h0, 32'h0000_0000, 1, 0, 8'h00};
        vecs[17] = '{0, 0, 0, 0, 32'h0,     0, 0, 8'h0, 32'h0000_0000, 0, 0, 8'h00};

        reset = 1'b1; sel = 1'b0; addr = 2'd0; wr_en = 1'b0; rd_en = 1'b0;
        wdata = '0; tx_data_ack = 1'b0; rx_data = '0; rx_data_fresh = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("reset irq", {31'b0, irq}, 32'h0);
        chk("reset tx_valid", {31'b0, tx_data_valid}, 32'h0);

        // Table: reset STATUS, TX of three bytes with acks, CTRL and tx_empty irq
        for (int i = 0; i < 18; i++) begin
            op(vecs[i].s, vecs[i].a, vecs[i].w, vecs[i].r, vecs[i].d,
               vecs[i].ack, vecs[i].fr, vecs[i].rx);
            chk($sformatf("vec%0d rdata", i), rdata, vecs[i].e_rdata);
            chk($sformatf("vec%0d irq", i), {31'b0, irq}, {31'b0, vecs[i].e_irq});
            chk($sformatf("vec%0d tx_valid", i), {31'b0, tx_data_valid}, {31'b0, vecs[i].e_txv});
            chk($sformatf("vec%0d tx_data", i), {24'b0, tx_data}, {24'b0, vecs[i].e_txd});
        end

        // TX overflow: 17 writes with no ack
        for (int i = 0; i < 17; i++) wr(2'd0, 32'h60 + i);
        rreg(2'd1);
        chk("txovf status", rdata, 32'h0010_0028);
        chk("txovf head", {24'b0, tx_data}, 32'h60);
        wr(2'd2, 32'h4);
        chk("err irq before", {31'b0, irq}, 32'h0);
        idle();
        chk("err irq lag", {31'b0, irq}, 32'h0);
        idle();
        chk("err irq set", {31'b0, irq}, 32'h1);
        wr(2'd1, 32'h20);
        chk("w1c irq hold", {31'b0, irq}, 32'h1);
        rreg(2'd1);
        chk("w1c status", rdata, 32'h0010_0008);
        chk("w1c irq lag", {31'b0, irq}, 32'h1);
        idle();
        chk("w1c irq clear", {31'b0, irq}, 32'h0);
        wr(2'd2, 32'h0);
        for (int i = 0; i < 16; i++) begin
            ack();
            chk($sformatf("drain tx%0d", i), {23'b0, tx_data_valid, tx_data}, 32'h160 + i);
        end
        idle();
        chk("drain tx empty", {31'b0, tx_data_valid}, 32'h0);

        // RX threshold interrupt
        wr(2'd2, 32'h301);
        fresh(8'h10);
        fresh(8'h11);
        fresh(8'h12);
        chk("thr irq pre", {31'b0, irq}, 32'h0);
        idle();
        chk("thr irq lag", {31'b0, irq}, 32'h0);
        rpop();
        chk("thr rd0", rdata, 32'h10);
        chk("thr irq set", {31'b0, irq}, 32'h1);
        rpop();
        chk("thr rd1", rdata, 32'h11);
        chk("thr irq hold", {31'b0, irq}, 32'h1);
        rpop();
        chk("thr rd2", rdata, 32'h12);
        chk("thr irq clear", {31'b0, irq}, 32'h0);
        wr(2'd2, 32'h0);

        // RX full: simultaneous push+pop, then a lone overflow push
        for (int i = 0; i < 16; i++) fresh(8'(i));
        rreg(2'd1);
        chk("rxfull status", rdata, 32'h0000_1007);
        op(1'b1, 2'd0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 8'hAA);
        chk("rxfull pushpop rd", rdata, 32'h00);
        rreg(2'd1);
        chk("rxfull no overrun", rdata, 32'h0000_1007);
        fresh(8'hBB);
        rreg(2'd1);
        chk("rxfull overrun", rdata, 32'h0000_1017);
        for (int i = 1; i < 16; i++) begin
            rpop();
            chk($sformatf("drain rx%0d", i), rdata, 32'(i));
        end
        rpop();
        chk("drain rx AA", rdata, 32'hAA);
        rpop();
        chk("empty rx read", rdata, 32'h0);
        rreg(2'd1);
        chk("empty rx status", rdata, 32'h0000_0014);
        wr(2'd1, 32'h10);
        rreg(2'd1);
        chk("overrun w1c", rdata, 32'h0000_0004);

        // Reset mid-transfer; rx_thresh 0 behaves as 1
        wr(2'd2, 32'h7);
        for (int i = 0; i < 5; i++) wr(2'd0, 32'h80 + i);
        fresh(8'h21);
        fresh(8'h22);
        rreg(2'd3);
        chk("thresh0 pend", rdata, 32'h1);
        idle();
        chk("pre-reset irq", {31'b0, irq}, 32'h1);
        @(posedge clk);
        #1;
        reset = 1'b1; sel = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        tx_data_ack = 1'b1; rx_data_fresh = 1'b0;
        @(negedge clk);
        rreg(2'd1);
        chk("post-reset status", rdata, 32'h0000_0004);
        chk("post-reset irq", {31'b0, irq}, 32'h0);
        chk("post-reset tx_valid", {31'b0, tx_data_valid}, 32'h0);
        chk("post-reset tx_data", {24'b0, tx_data}, 32'h0);
        rreg(2'd2);
        chk("post-reset ctrl", rdata, 32'h0);
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_mmio_fifo.md
# uart_mmio_fifo

Memory-mapped UART front-end that replaces the bare single-byte RX register and unbuffered TX strobe in the SoC with parametrised TX/RX FIFOs, a status register, programmable interrupt enables and an RX threshold. It sits between the core's data-bus address decode (device space, 0x0002_1000 window) and the existing `uart` serial core. It drives `ext_irq_r` through its `irq` output.

## Interface
Parameters:
- `XLEN`, 32, bus data width.
- `TX_DEPTH`, 16, TX FIFO entries; power of two, 2..128.
- `RX_DEPTH`, 16, RX FIFO entries; power of two, 2..128.

Ports:
- `clk`  in  1  single clock, the CPU clock domain.
- `reset`  in  1  synchronous, active-high.
- `sel`  in  1  address decode hit for this block's 16-byte window.
- `addr`  in  2  word offset, which is dataaddr[3:2].
- `wr_en`  in  1  write strobe; effective only with `sel`.
- `rd_en`  in  1  one-cycle read-commit strobe; effective only with `sel`; pops RX on DATA.
- `wdata`  in  XLEN  write data.
- `rdata`  out  XLEN  combinational read data; 0 when `sel`=0.
- `irq`  out  1  registered level interrupt.
- `tx_data`  out  8  byte to the serial core.
- `tx_data_valid`  out  1  TX FIFO non-empty.
- `tx_data_ack`  in  1  serial core consumed `tx_data`.
- `rx_data`  in  8  received byte.
- `rx_data_fresh`  in  1  one-cycle pulse; `rx_data` is valid.

## Operation
Registers, by `addr`:
- 0 DATA
  - Write: push wdata[7:0] into TX.
  - Read: returns {24'h0, RX head}; an `rd_en` pops RX.
  - Read of an empty RX returns 0 and does not pop.
- 1 STATUS, read-only except the sticky bits.
  - [0] rx_nonempty, [1] rx_full, [2] tx_empty, [3] tx_full.
  - [4] rx_overrun (sticky), [5] tx_drop (sticky).
  - [15:8] rx_count, [23:16] tx_count.
  - Writing 1 to bit 4 or bit 5 clears that sticky bit.
- 2 CTRL, R/W.
  - [0] rx_ie, [1] tx_empty_ie, [2] err_ie.
  - [15:8] rx_thresh; a value of 0 is treated as 1.
- 3 IRQ_PEND, read-only. [0] rx_pend, [1] tx_pend, [2] err_pend.

FIFO behaviour:
- TX FIFO
  - Push on a DATA write; pop when `tx_data_valid & tx_data_ack`.
  - A push into a full FIFO with no pop in the same cycle is dropped and sets tx_drop.
- RX FIFO
  - Push on `rx_data_fresh`; pop on a DATA read commit.
  - A push into a full FIFO with no pop in the same cycle is dropped and sets rx_overrun.
- Simultaneous push and pop is always legal. With both FIFOs full, push+pop leaves the count unchanged.
- Pointers wrap modulo DEPTH. Counts are $clog2(DEPTH+1) bits wide, zero-extended into their STATUS fields.

Interrupt pending terms:
- rx_pend = rx_count ≥ rx_thresh.
- tx_pend = tx_empty.
- err_pend = rx_overrun | tx_drop.

Interrupt output:
- `irq` next = |(pend & {err_ie, tx_empty_ie, rx_ie}).
- `irq` is level-sensitive. It clears only when the cause is removed.

Other rules:
- A write to STATUS does not affect the FIFOs.
- A sticky set and a W1C clear in the same cycle: the set wins.

## Timing
- Reset clears both FIFOs (counts 0, pointers 0), CTRL, sticky bits and `irq`. After reset:
  - `tx_data_valid`=0 and `tx_data`=0.
  - STATUS reads 0x0000_0004, since tx_empty=1.
- DATA write on edge N: `tx_data_valid`=1 from cycle N+1. `tx_data` is always the TX head, with no extra register stage.
- `tx_data_ack` is sampled only while `tx_data_valid`=1. The next byte, if any, is presented the cycle after the ack.
- `rx_data_fresh` at edge N: the byte is readable, and rx_count is updated, from cycle N+1.
- `rdata` is combinational from the current state. A pop takes effect at the edge where `rd_en` is high.
- `irq` has 1 cycle of latency from any state change: a register update at edge N makes `irq` change at edge N+1.
- A reset asserted mid-transfer discards FIFO contents on that edge. An in-flight ack in the same cycle is ignored.

## Structure
- Sub-module `cpu6_sync_fifo` with parameters WIDTH and DEPTH.
  - Outputs: head, count, full, empty.
  - Inputs: push, pop, din.
  - It is instantiated twice, for TX and RX.
- Shared constants belong in the cpu6 defines/package file: register offsets (UART_DATA=0, UART_STATUS=1, UART_CTRL=2, UART_IRQ=3), STATUS/CTRL bit positions, and the block base address 0x0002_1000.
- The serial core `uart` stays outside the block. `soc_top` wires it to the `tx_*` and `rx_*` ports.

## Test plan
- Reset, then read STATUS: 0x0000_0004. `irq`=0, `tx_data_valid`=0.
- Write 0x41, 0x42, 0x43 to DATA; ack each byte one cycle after valid rises. `tx_data` shows 0x41, 0x42, 0x43 in order; tx_count goes 3→0; tx_empty returns to 1.
- With TX_DEPTH=16 and no ack, write 17 bytes: tx_count=16, tx_full=1, tx_drop=1. With err_ie=1, `irq`=1 one cycle later. W1C bit 5 clears tx_drop, then `irq` drops.
- CTRL rx_thresh=3, rx_ie=1; pulse `rx_data_fresh` with 0x10, 0x11, 0x12. `irq` rises 1 cycle after the third push. Three DATA reads return 0x10, 0x11, 0x12; `irq` falls after rx_count drops below 3.
- Fill RX to 16 entries, then drive `rx_data_fresh` and a DATA `rd_en` in the same cycle. rx_count stays 16 and no overrun is flagged. A lone 17th push sets rx_overrun and drops the byte.
- Assert `reset` while the TX FIFO holds 5 bytes and the RX FIFO holds 2. Next cycle: counts are 0, `tx_data_valid`=0, CTRL=0, `irq`=0.
